// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, NZCV bit positions and opcode class helpers
// used by the writeback stage to decide flag commit and writeback behaviour.
package alu_pkg;

  localparam logic [3:0] ALU_OP_AND = 4'b0000;
  localparam logic [3:0] ALU_OP_EOR = 4'b0001;
  localparam logic [3:0] ALU_OP_LSL = 4'b0010;
  localparam logic [3:0] ALU_OP_LSR = 4'b0011;
  localparam logic [3:0] ALU_OP_ASR = 4'b0100;
  localparam logic [3:0] ALU_OP_ADC = 4'b0101;
  localparam logic [3:0] ALU_OP_SBC = 4'b0110;
  localparam logic [3:0] ALU_OP_ROR = 4'b0111;
  localparam logic [3:0] ALU_OP_TST = 4'b1000;
  localparam logic [3:0] ALU_OP_NEG = 4'b1001;
  localparam logic [3:0] ALU_OP_CMP = 4'b1010;
  localparam logic [3:0] ALU_OP_CMN = 4'b1011;
  localparam logic [3:0] ALU_OP_ORR = 4'b1100;
  localparam logic [3:0] ALU_OP_MUL = 4'b1101;
  localparam logic [3:0] ALU_OP_BIC = 4'b1110;
  localparam logic [3:0] ALU_OP_MVN = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Compare-class ops only affect flags; they never produce a register writeback.
  function automatic logic is_cmp_op(input logic [3:0] op);
    return op inside {ALU_OP_TST, ALU_OP_CMP, ALU_OP_CMN};
  endfunction

  function automatic logic is_arith_flag_op(input logic [3:0] op);
    return op inside {ALU_OP_ADC, ALU_OP_SBC, ALU_OP_NEG, ALU_OP_CMP, ALU_OP_CMN};
  endfunction

  // Logical/shift ops refresh N and Z only; C and V keep their previous value.
  function automatic logic is_logic_flag_op(input logic [3:0] op);
    return op inside {ALU_OP_AND, ALU_OP_EOR, ALU_OP_LSL, ALU_OP_LSR, ALU_OP_ASR,
                      ALU_OP_ROR, ALU_OP_TST, ALU_OP_ORR, ALU_OP_MUL, ALU_OP_BIC,
                      ALU_OP_MVN};
  endfunction

endpackage

// File: rtl/alu_wb_stage_wb_fifo.sv
// Small synchronous FIFO holding pending register-file writebacks.
// The head entry is read straight from the storage array and reads as zero when empty.
module wb_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule

// File: rtl/alu_wb_stage.sv
// Stage behind the combinational ALU: commits NZCV flags, feeds C back to the ALU,
// and buffers register writebacks so a stalled register-file port loses nothing.
module alu_wb_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_c,
  input  logic              in_z,
  input  logic              in_n,
  input  logic              in_v,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_set_flags,
  input  logic              flag_ld,
  input  logic [3:0]        flag_ld_val,
  output logic [3:0]        flags,
  output logic              c_flag,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [3:0]             r_flags;
  logic                   w_accept;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [CNT_W-1:0]       w_count;
  logic [ADDR_W+DATA_W-1:0] w_head;

  // A pending flag load blocks acceptance so an ALU commit never races the restore.
  assign in_ready = (w_count < CNT_W'(DEPTH)) & ~flag_ld & ~reset;
  assign w_accept = in_valid & in_ready;
  assign w_push   = w_accept & ~is_cmp_op(in_op) & ~w_full;
  assign w_pop    = wb_valid & wb_ready;

  wb_fifo #(
    .WIDTH(ADDR_W + DATA_W),
    .DEPTH(DEPTH)
  ) u_wb_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_push),
    .i_data ({in_rd, in_result}),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_count(w_count)
  );

  assign wb_valid = ~w_empty;
  assign wb_addr  = w_head[ADDR_W+DATA_W-1:DATA_W];
  assign wb_data  = w_head[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= '0;
    end else if (flag_ld) begin
      r_flags <= flag_ld_val;
    end else if (w_accept && in_set_flags) begin
      if (is_arith_flag_op(in_op)) begin
        r_flags[FLAG_N] <= in_n;
        r_flags[FLAG_Z] <= in_z;
        r_flags[FLAG_C] <= in_c;
        r_flags[FLAG_V] <= in_v;
      end else if (is_logic_flag_op(in_op)) begin
        r_flags[FLAG_N] <= in_n;
        r_flags[FLAG_Z] <= in_z;
      end
    end
  end

  assign flags  = r_flags;
  assign c_flag = r_flags[FLAG_C];

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed self-checking bench for alu_wb_stage: reset, flag commit classes, compare ops,
// writeback backpressure/ordering, external flag load and mid-operation reset.
module tb_alu_wb_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_result;
  logic        in_c, in_z, in_n, in_v;
  logic [2:0]  in_rd;
  logic        in_set_flags;
  logic        flag_ld;
  logic [3:0]  flag_ld_val;
  logic [3:0]  flags;
  logic        c_flag;
  logic        wb_valid;
  logic        wb_ready;
  logic [2:0]  wb_addr;
  logic [31:0] wb_data;

  int total = 0;
  int bad   = 0;

  alu_wb_stage #(.DATA_W(32), .ADDR_W(3), .DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_result   (in_result),
    .in_c        (in_c),
    .in_z        (in_z),
    .in_n        (in_n),
    .in_v        (in_v),
    .in_rd       (in_rd),
    .in_set_flags(in_set_flags),
    .flag_ld     (flag_ld),
    .flag_ld_val (flag_ld_val),
    .flags       (flags),
    .c_flag      (c_flag),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1ns so inputs change and outputs are sampled away from the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] res, input logic n, input logic z,
                       input logic c, input logic v, input logic [2:0] rd, input logic setf);
    in_valid = 1'b1; in_op = op; in_result = res;
    in_n = n; in_z = z; in_c = c; in_v = v; in_rd = rd; in_set_flags = setf;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(4'b0101, 32'h1234_5678, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready cyc%0d got %b want 0", i, in_ready); end
      total++; if (wb_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_wb_valid cyc%0d got %b want 0", i, wb_valid); end
      total++; if (flags !== 4'b0000) begin bad++; $display("[TB] FAIL reset_flags cyc%0d got %b want 0000", i, flags); end
    end
    total++; if ({wb_addr, wb_data} !== 35'd0) begin bad++; $display("[TB] FAIL reset_wb_bus got %h/%h want 0/0", wb_addr, wb_data); end
    reset = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_in_ready got %b want 1", in_ready); end
    cycle();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_wb_valid got %b want 0", wb_valid); end
  endtask

  task automatic test_adc();
    wb_ready = 1'b1;
    drive(4'b0101, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1);
    cycle();
    in_valid = 1'b0;
    total++; if (flags !== 4'b0110) begin bad++; $display("[TB] FAIL adc_flags got %b want 0110", flags); end
    total++; if (c_flag !== 1'b1) begin bad++; $display("[TB] FAIL adc_c_flag got %b want 1", c_flag); end
    total++; if (wb_valid !== 1'b1) begin bad++; $display("[TB] FAIL adc_wb_valid got %b want 1", wb_valid); end
    total++; if (wb_addr !== 3'd3) begin bad++; $display("[TB] FAIL adc_wb_addr got %0d want 3", wb_addr); end
    total++; if (wb_data !== 32'h0) begin bad++; $display("[TB] FAIL adc_wb_data got %h want 0", wb_data); end
    cycle();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("[TB] FAIL adc_popped got %b want 0", wb_valid); end
  endtask

  task automatic test_logic_keeps_cv();
    flag_ld = 1'b1; flag_ld_val = 4'b0011;
    cycle();
    flag_ld = 1'b0;
    total++; if (flags !== 4'b0011) begin bad++; $display("[TB] FAIL logic_preload got %b want 0011", flags); end
    drive(4'b0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1);
    cycle();
    in_valid = 1'b0;
    total++; if (flags !== 4'b1011) begin bad++; $display("[TB] FAIL and_flags got %b want 1011", flags); end
    total++; if ({wb_valid, wb_addr, wb_data} !== {1'b1, 3'd5, 32'h8000_0000}) begin
      bad++; $display("[TB] FAIL and_wb got v=%b a=%0d d=%h want v=1 a=5 d=80000000", wb_valid, wb_addr, wb_data); end
    // ADC without set_flags must leave NZCV alone but still write back.
    drive(4'b0101, 32'h0000_0042, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0);
    cycle();
    in_valid = 1'b0;
    total++; if (flags !== 4'b1011) begin bad++; $display("[TB] FAIL noset_flags got %b want 1011", flags); end
    total++; if ({wb_valid, wb_addr, wb_data} !== {1'b1, 3'd2, 32'h0000_0042}) begin
      bad++; $display("[TB] FAIL noset_wb got v=%b a=%0d d=%h want v=1 a=2 d=00000042", wb_valid, wb_addr, wb_data); end
    cycle();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("[TB] FAIL noset_popped got %b want 0", wb_valid); end
  endtask

  task automatic test_cmp();
    drive(4'b1010, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd7, 1'b1);
    cycle();
    in_valid = 1'b0;
    total++; if (flags !== 4'b0110) begin bad++; $display("[TB] FAIL cmp_flags got %b want 0110", flags); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("[TB] FAIL cmp_wb_valid got %b want 0", wb_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL cmp_in_ready got %b want 1", in_ready); end
    // TST is logic-class: N,Z from ALU, C,V held at 1,0.
    drive(4'b1000, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1);
    cycle();
    in_valid = 1'b0;
    total++; if (flags !== 4'b1010) begin bad++; $display("[TB] FAIL tst_flags got %b want 1010", flags); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("[TB] FAIL tst_wb_valid got %b want 0", wb_valid); end
    // CMN is arithmetic-class: all four flags from ALU.
    drive(4'b1011, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1);
    cycle();
    in_valid = 1'b0;
    total++; if (flags !== 4'b0001) begin bad++; $display("[TB] FAIL cmn_flags got %b want 0001", flags); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("[TB] FAIL cmn_wb_valid got %b want 0", wb_valid); end
  endtask

  task automatic test_backpressure();
    wb_ready = 1'b0;
    drive(4'b1100, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0);
    cycle();
    total++; if ({in_ready, wb_valid, wb_addr} !== {1'b1, 1'b1, 3'd1}) begin
      bad++; $display("[TB] FAIL bp_first got rdy=%b v=%b a=%0d want rdy=1 v=1 a=1", in_ready, wb_valid, wb_addr); end
    drive(4'b1100, 32'hBBBB_0002, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0);
    cycle();
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_full_ready got %b want 0", in_ready); end
    total++; if ({wb_addr, wb_data} !== {3'd1, 32'hAAAA_0001}) begin
      bad++; $display("[TB] FAIL bp_head_hold got a=%0d d=%h want a=1 d=aaaa0001", wb_addr, wb_data); end
    drive(4'b1100, 32'hCCCC_0003, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0);
    cycle();
    total++; if ({in_ready, wb_addr, wb_data} !== {1'b0, 3'd1, 32'hAAAA_0001}) begin
      bad++; $display("[TB] FAIL bp_stall got rdy=%b a=%0d d=%h want rdy=0 a=1 d=aaaa0001", in_ready, wb_addr, wb_data); end
    wb_ready = 1'b1;
    cycle();
    total++; if ({in_ready, wb_valid, wb_addr, wb_data} !== {1'b1, 1'b1, 3'd2, 32'hBBBB_0002}) begin
      bad++; $display("[TB] FAIL bp_pop_a got rdy=%b v=%b a=%0d d=%h want rdy=1 v=1 a=2 d=bbbb0002", in_ready, wb_valid, wb_addr, wb_data); end
    // Third entry is pushed on the same edge that B pops.
    cycle();
    in_valid = 1'b0;
    total++; if ({wb_valid, wb_addr, wb_data} !== {1'b1, 3'd4, 32'hCCCC_0003}) begin
      bad++; $display("[TB] FAIL bp_pushpop got v=%b a=%0d d=%h want v=1 a=4 d=cccc0003", wb_valid, wb_addr, wb_data); end
    cycle();
    total++; if ({wb_valid, wb_addr, wb_data} !== {1'b0, 3'd0, 32'h0}) begin
      bad++; $display("[TB] FAIL bp_drained got v=%b a=%0d d=%h want v=0 a=0 d=0", wb_valid, wb_addr, wb_data); end
  endtask

  task automatic test_flag_ld();
    drive(4'b0101, 32'hDDDD_0004, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 1'b1);
    flag_ld = 1'b1; flag_ld_val = 4'b1001;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL ld_in_ready got %b want 0", in_ready); end
    cycle();
    flag_ld = 1'b0;
    total++; if (flags !== 4'b1001) begin bad++; $display("[TB] FAIL ld_flags got %b want 1001", flags); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("[TB] FAIL ld_no_accept got %b want 0", wb_valid); end
    cycle();
    in_valid = 1'b0;
    total++; if (flags !== 4'b0000) begin bad++; $display("[TB] FAIL ld_then_adc_flags got %b want 0000", flags); end
    total++; if ({wb_valid, wb_addr, wb_data} !== {1'b1, 3'd6, 32'hDDDD_0004}) begin
      bad++; $display("[TB] FAIL ld_then_adc_wb got v=%b a=%0d d=%h want v=1 a=6 d=dddd0004", wb_valid, wb_addr, wb_data); end
    cycle();
  endtask

  task automatic test_reset_mid();
    wb_ready = 1'b0;
    flag_ld = 1'b1; flag_ld_val = 4'b1111;
    cycle();
    flag_ld = 1'b0;
    drive(4'b1101, 32'hEEEE_0005, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0);
    cycle();
    cycle();
    in_valid = 1'b0;
    total++; if ({wb_valid, in_ready} !== 2'b10) begin bad++; $display("[TB] FAIL mid_full got v=%b rdy=%b want v=1 rdy=0", wb_valid, in_ready); end
    reset = 1'b1;
    cycle();
    total++; if ({wb_valid, in_ready, flags} !== 6'b000000) begin
      bad++; $display("[TB] FAIL mid_reset got v=%b rdy=%b f=%b want v=0 rdy=0 f=0000", wb_valid, in_ready, flags); end
    reset = 1'b0;
    wb_ready = 1'b1;
    cycle();
    total++; if ({wb_valid, in_ready, wb_data} !== {1'b0, 1'b1, 32'h0}) begin
      bad++; $display("[TB] FAIL mid_after got v=%b rdy=%b d=%h want v=0 rdy=1 d=0", wb_valid, in_ready, wb_data); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_result = '0;
    in_c = 1'b0; in_z = 1'b0; in_n = 1'b0; in_v = 1'b0; in_rd = '0;
    in_set_flags = 1'b0; flag_ld = 1'b0; flag_ld_val = '0; wb_ready = 1'b1;
    #2;
    test_reset();
    test_adc();
    test_logic_keeps_cv();
    test_cmp();
    test_backpressure();
    test_flag_ld();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
